// File: rtl/cache_way_output_select_if.sv
// Lookup-side and response-side bus of the cache way read-out stage.
// slave = the select stage, master = the lookup source / response consumer.
interface cache_way_output_select_if #(
  parameter int block_size = 128,
  parameter int num_ways   = 4,
  parameter int word_size  = 32
);
  localparam int offset_w = $clog2(block_size / word_size);

  logic                           lookup_valid_i;
  logic                           lookup_ready_o;
  logic [num_ways-1:0]            hit_way_i;
  logic [offset_w-1:0]            word_offset_i;
  logic [num_ways*block_size-1:0] data_ways_i;

  logic                           out_valid_o;
  logic                           out_ready_i;
  logic                           hit_o;
  logic                           multi_hit_o;
  logic [block_size-1:0]          data_block_o;
  logic [word_size-1:0]           data_word_o;

  modport slave (
    input  lookup_valid_i, hit_way_i, word_offset_i, data_ways_i, out_ready_i,
    output lookup_ready_o, out_valid_o, hit_o, multi_hit_o, data_block_o, data_word_o
  );

  modport master (
    output lookup_valid_i, hit_way_i, word_offset_i, data_ways_i, out_ready_i,
    input  lookup_ready_o, out_valid_o, hit_o, multi_hit_o, data_block_o, data_word_o
  );
endinterface

// File: rtl/cache_way_output_select.sv
// N-way cache read-out: selects hitting way block/word into a registered output, 1-cycle latency.
// Holds the result while out_ready_i is low; lookup_ready_o drops, so upstream stalls without loss.
module cache_way_output_select #(
  parameter int block_size = 128,
  parameter int num_ways   = 4,
  parameter int word_size  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  cache_way_output_select_if.slave     bus,
  input  logic                         counters_clear_i,
  output logic [15:0]                  hit_count_o,
  output logic [15:0]                  miss_count_o
);

  logic                  acc;
  logic                  any_hit;
  logic                  multi_hit;
  logic [block_size-1:0] sel_block;
  logic [word_size-1:0]  sel_word;

  logic                  out_valid_q, out_valid_d;
  logic                  hit_q, hit_d;
  logic                  multi_hit_q, multi_hit_d;
  logic [block_size-1:0] block_q, block_d;
  logic [word_size-1:0]  word_q, word_d;
  logic [15:0]           hit_cnt_q, hit_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;

  assign bus.lookup_ready_o = ~out_valid_q | bus.out_ready_i;
  assign acc                = bus.lookup_valid_i & bus.lookup_ready_o;

  // Lowest-indexed hitting way wins; a second set bit flags a multi-hit.
  // A miss leaves sel_block at zero so nothing stale reaches the output.
  always_comb begin
    sel_block = '0;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    for (int k = 0; k < num_ways; k++) begin
      if (bus.hit_way_i[k]) begin
        if (any_hit) begin
          multi_hit = 1'b1;
        end else begin
          sel_block = bus.data_ways_i[k*block_size +: block_size];
          any_hit   = 1'b1;
        end
      end
    end
    sel_word = sel_block[int'(bus.word_offset_i)*word_size +: word_size];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    hit_d       = hit_q;
    multi_hit_d = multi_hit_q;
    block_d     = block_q;
    word_d      = word_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    if (acc) begin
      out_valid_d = 1'b1;
      hit_d       = any_hit;
      multi_hit_d = multi_hit;
      block_d     = sel_block;
      word_d      = sel_word;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a coincident accept, which then goes uncounted.
    if (counters_clear_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (acc) begin
      if (any_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      multi_hit_q <= 1'b0;
      block_q     <= '0;
      word_q      <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      multi_hit_q <= multi_hit_d;
      block_q     <= block_d;
      word_q      <= word_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.hit_o        = hit_q;
  assign bus.multi_hit_o  = multi_hit_q;
  assign bus.data_block_o = block_q;
  assign bus.data_word_o  = word_q;
  assign hit_count_o      = hit_cnt_q;
  assign miss_count_o     = miss_cnt_q;

endmodule

// File: tb/tb_cache_way_output_select.sv
// Bench for cache_way_output_select: directed lookups, expectations queued at issue, popped by a monitor.
module tb_cache_way_output_select;
  localparam int BS = 128;
  localparam int NW = 4;
  localparam int WS = 32;

  typedef struct packed {
    logic          hit;
    logic          multi;
    logic [BS-1:0] blk;
    logic [WS-1:0] word;
    logic [15:0]   hc;
    logic [15:0]   mc;
  } exp_t;

  localparam logic [127:0] W0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] W1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] W2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] W3 = 128'h3F3E3D3C_3B3A3938_37363534_33323130;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clr;
  logic [15:0] hit_count, miss_count;
  logic [511:0] ways_a;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        sb[$];
  exp_t        got_r, exp_r;

  cache_way_output_select_if #(.block_size(BS), .num_ways(NW), .word_size(WS)) bus();

  cache_way_output_select #(.block_size(BS), .num_ways(NW), .word_size(WS)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .bus              (bus),
    .counters_clear_i (clr),
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every transfer on the output handshake is compared against the queue head.
  always @(negedge clk) begin
    if (rst_ni && bus.out_valid_o && bus.out_ready_i) begin
      got_r = '{bus.hit_o, bus.multi_hit_o, bus.data_block_o, bus.data_word_o, hit_count, miss_count};
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got %0h expected none", got_r);
      end else begin
        exp_r = sb.pop_front();
        chk("response", 256'(got_r), 256'(exp_r));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the lookup has been accepted.
  task automatic issue(input logic [3:0] hw, input logic [1:0] off, input exp_t e);
    int n;
    bus.lookup_valid_i = 1'b1;
    bus.hit_way_i      = hw;
    bus.word_offset_i  = off;
    bus.data_ways_i    = ways_a;
    n = 0;
    @(negedge clk);
    while (!bus.lookup_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.lookup_ready_o) begin
      n_checks++;
      $display("FAIL accept_timeout: got lookup_ready_o=0 expected 1 within 50 cycles");
    end else begin
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.lookup_valid_i = 1'b0;
  endtask

  initial begin
    ways_a             = {W3, W2, W1, W0};
    rst_ni             = 1'b1;
    clr                = 1'b0;
    bus.lookup_valid_i = 1'b0;
    bus.hit_way_i      = '0;
    bus.word_offset_i  = '0;
    bus.data_ways_i    = '0;
    bus.out_ready_i    = 1'b1;
    #1 rst_ni = 1'b0;
    #11;
    chk("reset_state", 256'({bus.lookup_ready_o, bus.out_valid_o, bus.hit_o, bus.multi_hit_o,
                              bus.data_block_o, bus.data_word_o, hit_count, miss_count}),
        256'({1'b1, 3'b000, 128'h0, 32'h0, 16'h0, 16'h0}));
    @(negedge clk) rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", 256'({bus.out_valid_o, hit_count, miss_count}), 256'(0));
    end
    @(posedge clk); #1;

    issue(4'b0100, 2'd2, '{1'b1, 1'b0, W2, 32'hCCCCCCCC, 16'd1, 16'd0});
    issue(4'b0000, 2'd1, '{1'b0, 1'b0, 128'h0, 32'h0, 16'd1, 16'd1});
    issue(4'b1010, 2'd3, '{1'b1, 1'b1, W1, 32'h1F1E1D1C, 16'd2, 16'd1});
    issue(4'b0001, 2'd0, '{1'b1, 1'b0, W0, 32'h03020100, 16'd3, 16'd1});
    issue(4'b1000, 2'd1, '{1'b1, 1'b0, W3, 32'h37363534, 16'd4, 16'd1});
    issue(4'b1111, 2'd2, '{1'b1, 1'b1, W0, 32'h0B0A0908, 16'd5, 16'd1});
    @(posedge clk); #1;

    // Backpressure: result held, a waiting second lookup is refused.
    bus.out_ready_i = 1'b0;
    issue(4'b0010, 2'd0, '{1'b1, 1'b0, W1, 32'h13121110, 16'd6, 16'd1});
    bus.lookup_valid_i = 1'b1;
    bus.hit_way_i      = 4'b0100;
    bus.word_offset_i  = 2'd3;
    repeat (5) begin
      @(negedge clk);
      chk("hold_under_backpressure",
          256'({bus.lookup_ready_o, bus.out_valid_o, bus.data_block_o, bus.data_word_o, hit_count}),
          256'({1'b0, 1'b1, W1, 32'h13121110, 16'd6}));
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_follows_out_ready", 256'(bus.lookup_ready_o), 256'(1));
    sb.push_back('{1'b1, 1'b0, W2, 32'hDDDDDDDD, 16'd7, 16'd1});
    @(posedge clk); #1;
    bus.lookup_valid_i = 1'b0;
    chk("consume_and_accept", 256'({bus.out_valid_o, bus.data_word_o}), 256'({1'b1, 32'hDDDDDDDD}));

    // Preload the hit counter to FFFE, then push it into saturation.
    for (int i = 8; i <= 65534; i++)
      issue(4'b0001, 2'd0, '{1'b1, 1'b0, W0, 32'h03020100, 16'(i), 16'd1});
    repeat (3) issue(4'b0001, 2'd0, '{1'b1, 1'b0, W0, 32'h03020100, 16'hFFFF, 16'd1});

    clr = 1'b1;
    issue(4'b0100, 2'd0, '{1'b1, 1'b0, W2, 32'hAAAAAAAA, 16'd0, 16'd0});
    clr = 1'b0;
    issue(4'b0000, 2'd3, '{1'b0, 1'b0, 128'h0, 32'h0, 16'd0, 16'd1});
    @(posedge clk); #1;

    // Reset while a result is pending: everything is discarded.
    bus.out_ready_i = 1'b0;
    issue(4'b0010, 2'd1, '{1'b1, 1'b0, W1, 32'h17161514, 16'd1, 16'd1});
    #2 rst_ni = 1'b0;
    #1;
    chk("reset_mid_transfer", 256'({bus.lookup_ready_o, bus.out_valid_o, bus.hit_o, bus.multi_hit_o,
                                     bus.data_block_o, bus.data_word_o, hit_count, miss_count}),
        256'({1'b1, 3'b000, 128'h0, 32'h0, 16'h0, 16'h0}));
    sb.delete();
    @(negedge clk);
    rst_ni          = 1'b1;
    bus.out_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_midreset", 256'({bus.out_valid_o, hit_count, miss_count}), 256'(0));
    end

    chk("scoreboard_drained", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
